// File: rtl/mem_pkg.sv
// Shared defaults and FSM encoding for the load/store/fetch memory access unit.
package mem_pkg;

    localparam int unsigned DEF_DATA_SIZE    = 32;
    localparam int unsigned DEF_ADDRESS_SIZE = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_CAP  = 3'd2,
        WR_DATA = 3'd3,
        WR_HOLD = 3'd4,
        FE_ADDR = 3'd5,
        FE_CAP  = 3'd6
    } state_t;

    function automatic int unsigned hold_cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/hold_counter.sv
// Down-counter timing the write-hold window; reloaded each time a store enters WR_DATA.
module hold_counter
    import mem_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 2
)(
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_dec,
    output logic o_last
);

    localparam int unsigned        CNT_W    = hold_cnt_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]   LOAD_VAL = CNT_W'(HOLD_CYCLES);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_last = (r_count <= CNT_W'(1));

endmodule

// File: rtl/mem_access_unit.sv
// Arbitrates core load/store requests and instruction fetches onto a single RAM port.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned DATA_SIZE      = DEF_DATA_SIZE,
    parameter int unsigned ADDRESS_SIZE   = DEF_ADDRESS_SIZE,
    parameter int unsigned WR_HOLD_CYCLES = 2
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0]    req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_SIZE-1:0]    rsp_rdata,
    input  logic                    fetch_req,
    input  logic [ADDRESS_SIZE-1:0] fetch_addr,
    output logic                    fetch_valid,
    output logic [DATA_SIZE-1:0]    instr,
    output logic                    ram_read_write,
    output logic [ADDRESS_SIZE-1:0] ram_address,
    output logic [DATA_SIZE-1:0]    ram_data_in,
    input  logic [DATA_SIZE-1:0]    ram_data_out,
    input  logic [DATA_SIZE-1:0]    ram_fetch_out
);

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic [ADDRESS_SIZE-1:0] r_faddr;
    logic [DATA_SIZE-1:0]    r_wdata;
    logic [DATA_SIZE-1:0]    r_ram_data_in;
    logic                    r_rsp_valid;
    logic [DATA_SIZE-1:0]    r_rsp_rdata;
    logic                    r_fetch_valid;
    logic [DATA_SIZE-1:0]    r_instr;

    logic w_data_accept;
    logic w_fetch_accept;
    logic w_cnt_load;
    logic w_cnt_dec;
    logic w_hold_last;
    logic w_store_done;

    hold_counter #(
        .HOLD_CYCLES (WR_HOLD_CYCLES)
    ) u_hold_counter (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_cnt_load),
        .i_dec  (w_cnt_dec),
        .o_last (w_hold_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (req_valid)      w_next = req_write ? WR_DATA : RD_ADDR;
                else if (fetch_req) w_next = FE_ADDR;
            end
            RD_ADDR: w_next = RD_CAP;
            RD_CAP:  w_next = IDLE;
            WR_DATA: w_next = (WR_HOLD_CYCLES == 0) ? IDLE : WR_HOLD;
            WR_HOLD: w_next = w_hold_last ? IDLE : WR_HOLD;
            FE_ADDR: w_next = FE_CAP;
            FE_CAP:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = (r_state == IDLE);
        w_data_accept  = (r_state == IDLE) && req_valid;
        w_fetch_accept = (r_state == IDLE) && !req_valid && fetch_req;
        w_cnt_load     = w_data_accept && req_write;
        w_cnt_dec      = (r_state == WR_HOLD);
        w_store_done   = ((r_state == WR_HOLD) && w_hold_last) ||
                         ((r_state == WR_DATA) && (WR_HOLD_CYCLES == 0));
        ram_read_write = !((r_state == WR_DATA) || (r_state == WR_HOLD));
        ram_address    = ((r_state == FE_ADDR) || (r_state == FE_CAP)) ? r_faddr : r_addr;
    end

    // Write data is launched at the end of WR_DATA so address and mode settle one cycle earlier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr        <= '0;
            r_faddr       <= '0;
            r_wdata       <= '0;
            r_ram_data_in <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_fetch_valid <= 1'b0;
            r_instr       <= '0;
        end else begin
            r_rsp_valid   <= 1'b0;
            r_fetch_valid <= 1'b0;
            if (w_data_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_fetch_accept) r_faddr <= fetch_addr;
            if (r_state == WR_DATA) r_ram_data_in <= r_wdata;
            if (r_state == RD_CAP) begin
                r_rsp_rdata <= ram_data_out;
                r_rsp_valid <= 1'b1;
            end
            if (w_store_done) begin
                r_rsp_rdata <= '0;
                r_rsp_valid <= 1'b1;
            end
            if (r_state == FE_CAP) begin
                r_instr       <= ram_fetch_out;
                r_fetch_valid <= 1'b1;
            end
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign fetch_valid = r_fetch_valid;
    assign instr       = r_instr;
    assign ram_data_in = r_ram_data_in;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a clocked RAM model that writes while ram_read_write is low.
module tb_mem_access_unit;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 16;
    localparam int unsigned HOLD = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_valid;
    logic [DW-1:0] instr;
    logic          ram_read_write;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;
    logic [DW-1:0] ram_fetch_out;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_errors = 0;

    mem_access_unit #(
        .DATA_SIZE      (DW),
        .ADDRESS_SIZE   (AW),
        .WR_HOLD_CYCLES (HOLD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_valid    (fetch_valid),
        .instr          (instr),
        .ram_read_write (ram_read_write),
        .ram_address    (ram_address),
        .ram_data_in    (ram_data_in),
        .ram_data_out   (ram_data_out),
        .ram_fetch_out  (ram_fetch_out)
    );

    always #5 clk = ~clk;

    // Poison value on the data bus while writing, so a capture during a write is visible.
    assign ram_data_out  = ram_read_write ? mem[ram_address] : 32'hBAD0_BAD0;
    assign ram_fetch_out = mem[ram_address];

    always @(posedge clk) begin
        if (!reset && !ram_read_write) mem[ram_address] = ram_data_in;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        int lat;
        @(negedge clk);
        check({tag, "_ready"}, req_ready, 1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = '0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = i; break; end
        end
        check({tag, "_lat"}, lat, 2);
        check({tag, "_data"}, rsp_rdata, exp);
        @(negedge clk);
        check({tag, "_pulse"}, rsp_valid, 0);
    endtask

    task automatic do_store(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] prev_din);
        int lat;
        int low;
        logic addr_ok;
        logic din_ok;
        logic first;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99; low = 0; addr_ok = 1'b1; din_ok = 1'b1; first = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!ram_read_write) begin
                low++;
                if (ram_address !== a) addr_ok = 1'b0;
                if (first) begin
                    check({tag, "_din_late"}, ram_data_in, prev_din);
                    first = 1'b0;
                end else if (ram_data_in !== d) begin
                    din_ok = 1'b0;
                end
            end
            if (rsp_valid) begin lat = i; break; end
        end
        check({tag, "_low"}, low, 1 + HOLD);
        check({tag, "_addr"}, addr_ok, 1);
        check({tag, "_din"}, din_ok, 1);
        check({tag, "_lat"}, lat, HOLD + 1);
        check({tag, "_rdata0"}, rsp_rdata, 0);
        @(negedge clk);
        check({tag, "_pulse"}, rsp_valid, 0);
    endtask

    initial begin
        int lat;
        logic early_fetch;
        logic saw_rsp;
        logic [DW-1:0] w;

        mem[16'h0000] = 32'h1234_5678;
        mem[16'h0004] = 32'h0000_00A5;
        mem[16'h0008] = 32'h1111_2222;
        mem[16'h0010] = 32'h0000_0000;
        mem[16'h0011] = 32'h0000_0000;
        mem[16'h0020] = 32'hCAFE_0001;
        mem[16'h0030] = 32'h0000_0000;
        mem[16'hFFFF] = 32'h0000_0000;

        // Reset state
        @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_fetch_valid", fetch_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_instr", instr, 0);
        check("rst_rw", ram_read_write, 1);
        check("rst_addr", ram_address, 0);
        check("rst_din", ram_data_in, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", req_ready, 1);

        do_load("ld_a4", 16'h0004, 32'h0000_00A5);
        do_load("ld_zero", 16'h0000, 32'h1234_5678);
        do_store("st_max", 16'hFFFF, 32'hDEAD_BEEF, 32'h0000_0000);
        do_load("ld_max", 16'hFFFF, 32'hDEAD_BEEF);

        // Load and fetch requested together: load first
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0008;
        fetch_req = 1'b1; fetch_addr = 16'h0020;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99; early_fetch = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fetch_valid) early_fetch = 1'b1;
            if (rsp_valid) begin lat = i; break; end
        end
        check("pri_lat", lat, 2);
        check("pri_data", rsp_rdata, 32'h1111_2222);
        check("pri_order", early_fetch, 0);
        @(posedge clk);
        #1 fetch_req = 1'b0;
        lat = 99;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fetch_valid) begin lat = i; break; end
        end
        check("fe_lat", lat, 2);
        check("fe_instr", instr, 32'hCAFE_0001);
        @(negedge clk);
        check("fe_pulse", fetch_valid, 0);

        // Back-to-back stores with identical data
        do_store("b2b_a", 16'h0010, 32'h5A5A_5A5A, 32'hDEAD_BEEF);
        do_store("b2b_b", 16'h0011, 32'h5A5A_5A5A, 32'h5A5A_5A5A);
        do_load("b2b_ld_a", 16'h0010, 32'h5A5A_5A5A);
        do_load("b2b_ld_b", 16'h0011, 32'h5A5A_5A5A);
        check("din_hold", ram_data_in, 32'h5A5A_5A5A);

        // Reset in the second WR_HOLD cycle
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0030; req_wdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_rw", ram_read_write, 1);
        check("mid_rst_rsp", rsp_valid, 0);
        check("mid_rst_ready", req_ready, 1);
        saw_rsp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        check("mid_rst_norsp", saw_rsp, 0);
        check("mid_rst_din", ram_data_in, 0);
        check("mid_rst_addr", ram_address, 0);
        w = mem[16'h0030];
        check("mid_rst_mem", (w === 32'h0000_0000) || (w === 32'h0BAD_F00D), 1);
        do_load("post_rst_ld", 16'h0030, w);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
